// File: rtl/ws2812_frame_sequencer.sv
// WS2812 frame scheduler: fetches NUM_LEDS RGB pixels from a synchronous pixel RAM
// and streams them in G,R,B byte order through the output shifter handshake.
module ws2812_frame_sequencer #(
    parameter int unsigned NUM_LEDS     = 60,
    parameter int unsigned FRAME_PERIOD = 200000,
    parameter int unsigned ADDR_WIDTH   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  force_frame,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [23:0]           mem_rdata,
    output logic                  sh_trigger,
    output logic [7:0]            sh_data,
    output logic                  sh_valid,
    input  logic                  sh_request,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_overrun
);

    localparam int unsigned TIMER_WIDTH = $clog2(FRAME_PERIOD);
    localparam logic [TIMER_WIDTH-1:0] TICK_AT = TIMER_WIDTH'(FRAME_PERIOD - 1);
    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX = ADDR_WIDTH'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TRIGGER,
        STREAM,
        DRAIN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [TIMER_WIDTH-1:0]  timer;
    logic                    pending;
    logic [23:0]             pix;
    logic [23:0]             nxt;
    logic                    nxt_full;
    logic [1:0]              byte_idx;
    logic [ADDR_WIDTH-1:0]   pix_idx;
    logic                    rd_vld;

    logic tick;
    logic last_pix;
    logic consume;

    assign tick     = (timer == TICK_AT);
    assign last_pix = (pix_idx == LAST_IDX);
    assign consume  = sh_request & sh_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the combinational shifter-facing outputs
    always_comb begin
        state_next = state;
        sh_valid   = 1'b0;
        sh_data    = 8'h00;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (rd_vld) begin
                    state_next = TRIGGER;
                end
            end
            TRIGGER: begin
                sh_valid = 1'b1;
                if (sh_request) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                sh_valid = (byte_idx < 2'd2) | nxt_full | last_pix;
                if (consume && byte_idx == 2'd2 && last_pix) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (sh_request) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (sh_valid) begin
            case (byte_idx)
                2'd0:    sh_data = pix[15:8];
                2'd1:    sh_data = pix[23:16];
                default: sh_data = pix[7:0];
            endcase
        end
    end

    // Frame timer, request bookkeeping, pixel fetch and byte sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            timer         <= '0;
            pending       <= 1'b0;
            pix           <= '0;
            nxt           <= '0;
            nxt_full      <= 1'b0;
            byte_idx      <= '0;
            pix_idx       <= '0;
            rd_vld        <= 1'b0;
            mem_addr      <= '0;
            mem_rd_en     <= 1'b0;
            sh_trigger    <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            timer      <= tick ? '0 : timer + TIMER_WIDTH'(1);
            mem_rd_en  <= 1'b0;
            frame_done <= 1'b0;
            rd_vld     <= mem_rd_en;

            // A request raised in the cycle it is consumed is dropped
            if (state == IDLE && pending) begin
                pending <= 1'b0;
            end else if ((tick && enable) || force_frame) begin
                pending <= 1'b1;
            end

            if (tick && enable && busy) begin
                frame_overrun <= 1'b1;
            end

            if (state == IDLE && pending) begin
                mem_addr  <= '0;
                mem_rd_en <= 1'b1;
                busy      <= 1'b1;
            end

            if (state == LOAD && rd_vld) begin
                pix        <= mem_rdata;
                byte_idx   <= '0;
                pix_idx    <= '0;
                nxt_full   <= 1'b0;
                sh_trigger <= 1'b1;
            end else if (rd_vld) begin
                nxt      <= mem_rdata;
                nxt_full <= 1'b1;
            end

            if (state == TRIGGER && sh_request) begin
                sh_trigger <= 1'b0;
            end

            if (consume) begin
                if (byte_idx == 2'd0 && !last_pix) begin
                    mem_addr  <= pix_idx + ADDR_WIDTH'(1);
                    mem_rd_en <= 1'b1;
                end
                if (byte_idx != 2'd2) begin
                    byte_idx <= byte_idx + 2'd1;
                end else if (!last_pix) begin
                    pix      <= nxt;
                    nxt_full <= 1'b0;
                    pix_idx  <= pix_idx + ADDR_WIDTH'(1);
                    byte_idx <= '0;
                end
            end

            if (state == DRAIN && sh_request) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

    // A mid-frame request without the next pixel loaded would end the LED frame early
    assert property (@(posedge clk) disable iff (rst)
        !(state == STREAM && sh_request && !sh_valid && !last_pix))
        else $error("ws2812_frame_sequencer: shifter request before next pixel was loaded");

endmodule
